fetch_hazard_ctrl: RTL

//  Sequences the IF/ID fetch pipeline register and the PC: produces enable/flush for IF/ID and

---
 rtl/fetch_hazard_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-side hazard sequencer: drives PC enable, IF/ID enable/flush and ID/EX flush
// from load-use hazards, taken branches and instruction-memory wait states. Also keeps
// saturating stall/flush counters and a sticky instruction-memory timeout flag.
module fetch_hazard_ctrl #(
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned IMEM_TIMEOUT   = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             imem_timeout
);

    // Flush counter only ever holds BRANCH_PENALTY-1 down to 1.
    localparam int unsigned FW = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
    localparam int unsigned WW = $clog2(IMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_ctr_q, flush_ctr_d;
    logic [WW-1:0]    wait_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             timeout_q;
    logic             hazard;
    logic             active;

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Counters and the wait monitor only run outside INIT and outside reset.
    assign active = !rst && (state_q != StInit);

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign imem_timeout = timeout_q;

    // Next-state and control outputs; INIT outputs are the defaults and also apply during rst.
    always_comb begin
        state_d     = state_q;
        flush_ctr_d = flush_ctr_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        if (rst) begin
            state_d = StInit;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (ex_branch_taken) begin
                        pc_en       = 1'b1;
                        flush_ctr_d = FW'(BRANCH_PENALTY - 1);
                        if (BRANCH_PENALTY > 1) state_d = StFlush;
                    end else if (hazard) begin
                        // Hold IF/ID, bubble EX.
                        ifid_flush = 1'b0;
                    end else if (!imem_ready) begin
                        idex_flush = 1'b0;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                StFlush: begin
                    // Branches and hazards are ignored here; EX holds a bubble.
                    pc_en = imem_ready;
                    if (flush_ctr_q == FW'(1)) begin
                        state_d = StRun;
                    end else begin
                        flush_ctr_d = flush_ctr_q - FW'(1);
                    end
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

    // FSM state and branch-penalty countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            flush_ctr_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
        end
    end

    // Saturating performance counters, imem wait monitor and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
        end else if (active) begin
            if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
            if (imem_ready) begin
                wait_q <= '0;
            end else if (wait_q != WW'(IMEM_TIMEOUT)) begin
                wait_q <= wait_q + 1'b1;
                if (wait_q == WW'(IMEM_TIMEOUT - 1)) timeout_q <= 1'b1;
            end
        end else begin
            wait_q <= '0;
        end
    end

endmodule
